uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's baud clock divider in the uart_echo design.
- Runs directly on hwclk and takes the same 32-bit period value the divider uses, so both ends agree on bit time.
- Bit time = 2*(period+1) hwclk cycles, which equals one full cycle of the divided clock.
- Synchronises the asynchronous rx line, validates the start bit at mid-bit, samples 8 data bits LSB first, checks the stop bit, and presents each byte with a one-cycle strobe.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rx synchroniser (minimum 2).
- DATA_BITS, 8, data bits per frame (supported range 5-8).

Ports:
- hwclk  input  1  system clock (12 MHz).
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- period  input  32  half-bit period minus one; bit time = 2*(period+1) cycles; must be >= 3; change only while busy=0.
- rx  input  1  serial line, idle high, asynchronous.
- data  output  DATA_BITS  last received byte; holds until the next good frame.
- valid  output  1  one-cycle strobe, data is new.
- framing_err  output  1  one-cycle strobe, stop bit sampled low.
- parity_err  output  1  one-cycle strobe, parity mismatch (see Optional Feature).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counters=0, synchroniser stages=1, data=0.
  - valid=framing_err=parity_err=0, busy=0.
- Synchroniser: rx passes through SYNC_STAGES flops, giving rx_s. All decisions use rx_s only. Latency rx to rx_s = SYNC_STAGES cycles.
- States: IDLE, START, DATA, STOP, BREAK. Cycle counter cnt is 32 bits and never wraps within a bit.
- IDLE:
  - rx_s==0 -> START, cnt=0.
  - busy rises on the cycle after entry to START.
- START:
  - cnt increments each cycle; at cnt==period (mid start bit), sample rx_s.
  - rx_s==0 -> DATA, cnt=0, bit index=0.
  - rx_s==1 -> glitch: return to IDLE with no strobe.
- DATA:
  - At cnt==2*period+1 (one full bit later), sample rx_s into shift register position bit index (LSB first), cnt=0, increment bit index.
  - After DATA_BITS samples -> STOP (or the parity bit state, when the optional feature is enabled).
- STOP: at cnt==2*period+1, sample rx_s.
  - rx_s==1: data<=shift register; valid=1 next cycle for exactly 1 cycle; -> IDLE.
  - rx_s==0: framing_err=1 for exactly 1 cycle; data unchanged; -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. A held-low line (break condition) produces exactly one framing_err, not repeated errors.
- Back-to-back frames: a start edge arriving on the cycle IDLE is re-entered is accepted. The receiver tolerates a stop bit of one full bit with no extra idle time.
- Strobes never overlap. valid and framing_err are mutually exclusive. parity_err may coincide with valid; data is still updated.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is discarded with no strobe.
- Period <3 or a period change while busy: undefined; the bench must not exercise it.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled one full bit after the last data bit.
  - Even parity: if XOR(data bits, parity bit) != 0, parity_err=1 for one cycle, coincident with valid.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state; parity_err tied to 0.

Test Plan:
- period=51 (bit time 104 cycles), send 0xA5 on rx -> exactly one valid pulse, data=0xA5, framing_err=0, busy high for about 10 bit times.
- period=51, rx pulse low for 20 cycles then high -> no valid/framing_err, busy drops back to 0 within 55 cycles.
- period=51, send 0x3C with stop bit forced 0, hold rx low for 300 cycles, then high -> one framing_err pulse, data keeps the prior value, no valid, returns to IDLE after rx rises.
- period=3, send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses, data=0x00 then 0xFF.
- period=51, assert reset during bit 4 of 0x81, release, send 0x42 -> no strobe for the aborted frame, then valid with data=0x42.
- UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> valid=1, data=0x07, parity_err=1; resend with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver clocked directly by hwclk.
// Bit time is 2*(period+1) hwclk cycles, matching the uart_echo baud divider.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line idle, waiting for synchronised rx low
// START  | timing to middle of start bit, rejecting glitches
// DATA   | sampling data bits one full bit apart, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN builds only)
// STOP   | sampling stop bit, presenting byte or flagging framing error
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8
) (
    input  logic                 hwclk,
    input  logic                 reset,
    input  logic [31:0]          period,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [31:0]            cnt_q;
    logic [31:0]            cnt_d;
    logic                   mid_hit;
    logic                   bit_hit;
    logic [IDX_W-1:0]       idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_q;
    logic                   perr_q;
`endif

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign cnt_d   = cnt_q + 32'd1;
    // Half a bit in: cnt reaches period. A full bit: cnt reaches 2*period+1,
    // compared at 33 bits so every period bit takes part.
    assign mid_hit = (cnt_q == period);
    assign bit_hit = ({1'b0, cnt_q} == {period, 1'b1});

    // Metastability synchroniser for the asynchronous rx line; idles high.
    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Frame FSM with registered strobes, data and busy.
    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (mid_hit) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_DATA: begin
                    if (bit_hit) begin
                        cnt_q   <= '0;
                        // Shifting in from the top leaves the first bit at LSB.
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_hit) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_hit) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= ^{shift_q, par_q};
`endif
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // One framing error per held-low line; leave only once it is high.
                S_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: a line-history frame model predicts every output per cycle.
module tb_uart_rx_sampler;

    localparam int S = 2;
    localparam int N = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PARB = 1;
`else
    localparam int PARB = 0;
`endif
    localparam int MAXC = 60000;
    localparam int A5_BUSY = 52 + (N + 1 + PARB) * 104;

    logic        hwclk  = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] period = 32'd51;
    logic        rx     = 1'b1;
    logic [7:0]  data;
    logic        valid;
    logic        framing_err;
    logic        parity_err;
    logic        busy;

    uart_rx_sampler #(.SYNC_STAGES(S), .DATA_BITS(N)) dut (
        .hwclk       (hwclk),
        .reset       (reset),
        .period      (period),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 hwclk = ~hwclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Effective line value seen at each clock edge (forced high while in reset).
    bit eff_hist [0:MAXC-1];
    int cyc = 0;

    function automatic bit line(input int idx);
        if (idx < 0) return 1'b1;
        return eff_hist[idx];
    endfunction

    // Model state: 0 idle, 1 in frame, 2 waiting out a break.
    int         m_mode = 0;
    int         m_e;
    int         m_p;
    logic [7:0] m_data = 8'h00;
    bit         ev, ef, ep;
    int         bt, mid, n;
    logic [7:0] mb;
    bit         pb, sb;

    // DUT-side observations.
    int         dut_nv = 0, dut_nf = 0, dut_np = 0, busy_cnt = 0;
    logic [7:0] dut_q[$];

    task automatic clr();
        dut_nv = 0; dut_nf = 0; dut_np = 0; busy_cnt = 0;
        dut_q.delete();
    endtask

    always @(posedge hwclk) begin
        n = cyc;
        cyc++;
        if (n >= MAXC) begin
            $display("FAIL cycle_budget: actual=%0d required<%0d", n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        eff_hist[n] = reset ? rx : 1'b1;
        ev = 0; ef = 0; ep = 0;
        if (!reset) begin
            m_mode = 0;
            m_data = 8'h00;
        end else if (m_mode == 0) begin
            if (!line(n - S)) begin
                m_mode = 1;
                m_e    = n - S;
                m_p    = int'(period);
            end
        end else if (m_mode == 1) begin
            bt  = 2 * (m_p + 1);
            mid = m_e + m_p + 1;
            if (n == mid + S) begin
                if (line(mid)) m_mode = 0;
            end else if (n == mid + S + (N + 1 + PARB) * bt) begin
                for (int i = 0; i < N; i++) mb[i] = line(mid + (i + 1) * bt);
                pb = line(mid + (N + 1) * bt);
                sb = line(mid + (N + 1 + PARB) * bt);
                if (sb) begin
                    ev     = 1;
                    m_data = mb;
                    ep     = (PARB != 0) && ((^mb) != pb);
                    m_mode = 0;
                end else begin
                    ef     = 1;
                    m_mode = 2;
                end
            end
        end else begin
            if (line(n - S)) m_mode = 0;
        end
        #1;
        chk("valid", valid, ev);
        chk("framing_err", framing_err, ef);
        chk("parity_err", parity_err, ep);
        chk("busy", busy, m_mode != 0);
        chk("data", data, m_data);
        if (valid) begin dut_nv++; dut_q.push_back(data); end
        if (framing_err) dut_nf++;
        if (parity_err) dut_np++;
        if (busy) busy_cnt++;
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge hwclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit pbit, input bit stop);
        int bti;
        bti = 2 * (int'(period) + 1);
        rx = 1'b0;
        wait_cycles(bti);
        for (int i = 0; i < N; i++) begin
            rx = b[i];
            wait_cycles(bti);
        end
        if (PARB != 0) begin
            rx = pbit;
            wait_cycles(bti);
        end
        rx = stop;
        wait_cycles(bti);
    endtask

    initial begin
        logic [7:0] rb;
        int kind, w;

        // Reset state
        wait_cycles(5);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 1'b0);
        reset = 1'b1;
        wait_cycles(10);

        // 0xA5 at period 51
        clr();
        send_frame(8'hA5, ^8'hA5, 1'b1);
        wait_cycles(20);
        chk("a5_nvalid", dut_nv, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_model", m_data, 8'hA5);
        chk("a5_nferr", dut_nf, 0);
        chk("a5_busy_cycles", busy_cnt, A5_BUSY);

        // 20-cycle glitch
        clr();
        rx = 1'b0;
        wait_cycles(20);
        rx = 1'b1;
        wait_cycles(60);
        chk("glitch_nvalid", dut_nv, 0);
        chk("glitch_nferr", dut_nf, 0);
        chk("glitch_busy_cycles", busy_cnt, 52);
        chk("glitch_idle", busy, 1'b0);

        // 0x3C with low stop bit, then held low as a break
        clr();
        send_frame(8'h3C, ^8'h3C, 1'b0);
        wait_cycles(300);
        chk("break_busy", busy, 1'b1);
        rx = 1'b1;
        wait_cycles(20);
        chk("break_nferr", dut_nf, 1);
        chk("break_nvalid", dut_nv, 0);
        chk("break_data", data, 8'hA5);
        chk("break_idle", busy, 1'b0);

        // Back-to-back at period 3
        period = 32'd3;
        clr();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        wait_cycles(20);
        chk("b2b_nvalid", dut_nv, 2);
        if (dut_q.size() == 2) begin
            chk("b2b_first", dut_q[0], 8'h00);
            chk("b2b_second", dut_q[1], 8'hFF);
        end
        chk("b2b_model", m_data, 8'hFF);

        // Reset in the middle of bit 4 of 0x81, then 0x42
        period = 32'd51;
        wait_cycles(5);
        clr();
        rx = 1'b0;
        wait_cycles(104);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            wait_cycles(104);
        end
        rx = 1'b0;
        wait_cycles(52);
        reset = 1'b0;
        rx = 1'b1;
        wait_cycles(10);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_data", data, 8'h00);
        reset = 1'b1;
        wait_cycles(20);
        chk("rst_abort_nvalid", dut_nv, 0);
        send_frame(8'h42, ^8'h42, 1'b1);
        wait_cycles(20);
        chk("rst_nvalid", dut_nv, 1);
        chk("rst_nferr", dut_nf, 0);
        chk("rst_data42", data, 8'h42);

`ifdef UART_RX_PARITY_EN
        clr();
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cycles(20);
        chk("par_bad_nperr", dut_np, 1);
        chk("par_bad_nvalid", dut_nv, 1);
        chk("par_bad_data", data, 8'h07);
        clr();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(20);
        chk("par_good_nperr", dut_np, 0);
        chk("par_good_nvalid", dut_nv, 1);
`endif

        // Randomised frames, glitches and breaks at assorted periods
        for (int f = 0; f < 40; f++) begin
            period = $urandom_range(15, 3);
            kind   = $urandom_range(9, 0);
            rb     = 8'($urandom);
            if (kind == 0) begin
                w  = $urandom_range(int'(period), 1);
                rx = 1'b0;
                wait_cycles(w);
                rx = 1'b1;
                wait_cycles(int'(period) + 8);
            end else if (kind == 1) begin
                send_frame(rb, ^rb, 1'b0);
                wait_cycles($urandom_range(40, 0));
                rx = 1'b1;
                wait_cycles(S + 4);
            end else begin
                send_frame(rb, ($urandom_range(3, 0) == 0) ? ~(^rb) : ^rb, 1'b1);
                if ($urandom_range(3, 0) != 0) wait_cycles($urandom_range(20, 1));
            end
        end
        rx = 1'b1;
        wait_cycles(50);
        chk("final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
